// File: rtl/alu_pkg.sv
// Shared ALU definitions: multiplier width and the multiply FSM state encoding.
package alu_pkg;

  localparam int MULT_W = 32;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Iteration counter width: enough to hold WIDTH-1 with a spare bit.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/subtract M into the upper part of P, then
// arithmetic-shift the whole of P right by one.
module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH+1:0] p,
  input  logic [WIDTH:0]     m,
  output logic [2*WIDTH+1:0] p_next
);

  logic [WIDTH:0] u;
  logic [WIDTH:0] u_sum;

  assign u = p[2*WIDTH+1:WIDTH+1];

  always_comb begin
    u_sum = u;
    case (p[1:0])
      2'b01:   u_sum = u + m;
      2'b10:   u_sum = u - m;
      default: u_sum = u;
    endcase
    // The sign of the widened accumulator feeds the vacated top bit.
    p_next = {u_sum[WIDTH], u_sum, p[WIDTH:1]};
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth signed multiplier: WIDTH iterations per product,
// registered low result and overflow window, one-cycle ready pulse.
module booth_mult_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH:0]   overflowBits,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  logic [1:0]           state_reg;
  logic [CNT_W-1:0]     counter_reg;
  logic [2*WIDTH+1:0]   p_reg;
  logic [2*WIDTH+1:0]   p_next;
  logic [WIDTH:0]       m_reg;
  logic [WIDTH-1:0]     result_reg;
  logic [WIDTH:0]       ovf_reg;
  logic                 rdy_reg;
  logic                 load;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .p      (p_reg),
    .m      (m_reg),
    .p_next (p_next)
  );

  // A new operation may start from IDLE or in the single DONE cycle.
  assign load = ctrl_MULT && (state_reg == ST_IDLE || state_reg == ST_DONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      counter_reg <= '0;
      p_reg       <= '0;
      m_reg       <= '0;
      result_reg  <= '0;
      ovf_reg     <= '0;
      rdy_reg     <= 1'b0;
    end else begin
      rdy_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (load) begin
            m_reg       <= {operandA[WIDTH-1], operandA};
            p_reg       <= {{(WIDTH+1){1'b0}}, operandB, 1'b0};
            counter_reg <= '0;
            state_reg   <= ST_RUN;
          end else begin
            state_reg   <= ST_IDLE;
          end
        end
        ST_RUN: begin
          p_reg       <= p_next;
          counter_reg <= counter_reg + CNT_W'(1);
          if (counter_reg == LAST_STEP) begin
            // Capture from the final step so the result is valid throughout DONE.
            state_reg  <= ST_DONE;
            result_reg <= p_next[WIDTH:1];
            ovf_reg    <= p_next[2*WIDTH:WIDTH];
            rdy_reg    <= 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign data_result    = result_reg;
  assign overflowBits   = ovf_reg;
  assign data_resultRDY = rdy_reg;
  assign busy           = (state_reg == ST_RUN);

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: fixed vector table, random operands
// against a plain-arithmetic product model, and multi-cycle corner sequences.
module tb_booth_mult_seq;

  localparam int W = 32;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           ctrl_MULT = 1'b0;
  logic [W-1:0]   operandA = '0;
  logic [W-1:0]   operandB = '0;
  logic [W-1:0]   data_result;
  logic [W:0]     overflowBits;
  logic           data_resultRDY;
  logic           busy;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W:0]   ovf;
  } vec_t;

  vec_t vecs[8];

  booth_mult_seq #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .operandA       (operandA),
    .operandB       (operandB),
    .data_result    (data_result),
    .overflowBits   (overflowBits),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    return sa * sb;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Waits (bounded) for the ready pulse; lat counts rising edges after the start edge.
  task automatic wait_rdy(output int lat);
    lat = 0;
    while (!data_resultRDY && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    @(negedge clock);
    ctrl_MULT = 1'b1;
    operandA  = a;
    operandB  = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    wait_rdy(lat);
  endtask

  initial begin
    int lat;
    int pulses;
    logic [2*W-1:0] prod;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vecs[0] = '{32'd3,          32'd4,          32'd12,         33'h0_0000_0000};
    vecs[1] = '{-32'sd7,        32'd6,          32'hFFFF_FFD6,  33'h1_FFFF_FFFF};
    vecs[2] = '{32'd65536,      32'd65536,      32'h0,          33'h0_0000_0002};
    vecs[3] = '{32'h8000_0000,  32'h8000_0000,  32'h0,          33'h0_8000_0000};
    vecs[4] = '{32'h7FFF_FFFF,  32'h7FFF_FFFF,  32'h1,          33'h0_7FFF_FFFE};
    vecs[5] = '{32'h8000_0000,  32'h7FFF_FFFF,  32'h8000_0000,  33'h1_8000_0001};
    vecs[6] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h1,          33'h0_0000_0000};
    vecs[7] = '{32'h0,          -32'sd5,        32'h0,          33'h0_0000_0000};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset_result", 64'(data_result), 64'h0);
    check("reset_ovf", 64'(overflowBits), 64'h0);
    check("reset_rdy", 64'(data_resultRDY), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    @(negedge clock);
    reset = 1'b1;

    // Fixed vectors; RDY is due 32 edges after the start edge (cycle start+33).
    for (int i = 0; i < 8; i++) begin
      do_op(vecs[i].a, vecs[i].b, lat);
      $display("vec %0d: a=%h b=%h result=%h ovf=%h lat=%0d", i, vecs[i].a, vecs[i].b,
               data_result, overflowBits, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
      check($sformatf("vec%0d_result", i), 64'(data_result), 64'(vecs[i].res));
      check($sformatf("vec%0d_ovf", i), 64'(overflowBits), 64'(vecs[i].ovf));
      check($sformatf("vec%0d_busy_done", i), 64'(busy), 64'h0);
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_rdy_width", i), 64'(data_resultRDY), 64'h0);
    end

    // Random operands against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) ra = {1'b1, 31'(ra[15:0])};
      prod = ref_prod(ra, rb);
      do_op(ra, rb, lat);
      $display("rnd %0d: a=%h b=%h result=%h ovf=%h", i, ra, rb, data_result, overflowBits);
      check($sformatf("rnd%0d_latency", i), 64'(lat), 64'd32);
      check($sformatf("rnd%0d_result", i), 64'(data_result), 64'(prod[W-1:0]));
      check($sformatf("rnd%0d_ovf", i), 64'(overflowBits), 64'(prod[2*W-1:W-1]));
    end

    // Mid-run start pulse with new operands is ignored
    @(negedge clock);
    ctrl_MULT = 1'b1;
    operandA  = 32'd1234;
    operandB  = -32'sd5;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    check("busy_in_run", 64'(busy), 64'h1);
    repeat (4) @(posedge clock);
    #1;
    ctrl_MULT = 1'b1;
    operandA  = 32'd99;
    operandB  = 32'd77;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    wait_rdy(lat);
    $display("interfere: result=%h ovf=%h lat=%0d", data_result, overflowBits, lat);
    check("interfere_latency", 64'(lat), 64'd27);
    check("interfere_result", 64'(data_result), 64'hFFFF_E7E6);
    check("interfere_ovf", 64'(overflowBits), 64'h1_FFFF_FFFF);
    @(posedge clock);
    #1;

    // Reset mid-run clears outputs at once and no pulse follows
    do_op(32'd3, 32'd4, lat);
    @(negedge clock);
    ctrl_MULT = 1'b1;
    operandA  = 32'd100;
    operandB  = 32'd100;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    repeat (9) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    $display("reset mid-run: result=%h ovf=%h busy=%0d", data_result, overflowBits, busy);
    check("midreset_result", 64'(data_result), 64'h0);
    check("midreset_busy", 64'(busy), 64'h0);
    check("midreset_ovf", 64'(overflowBits), 64'h0);
    @(negedge clock);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) pulses++;
    end
    check("midreset_no_rdy", 64'(pulses), 64'h0);

    // Back-to-back: new start accepted in the DONE cycle
    do_op(32'd5, 32'd7, lat);
    check("b2b_first_result", 64'(data_result), 64'd35);
    ctrl_MULT = 1'b1;
    operandA  = 32'd2;
    operandB  = -32'sd3;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    check("b2b_busy", 64'(busy), 64'h1);
    wait_rdy(lat);
    $display("b2b: result=%h ovf=%h lat=%0d", data_result, overflowBits, lat);
    check("b2b_latency", 64'(lat), 64'd32);
    check("b2b_second_result", 64'(data_result), 64'hFFFF_FFFA);
    check("b2b_second_ovf", 64'(overflowBits), 64'h1_FFFF_FFFF);
    @(posedge clock);
    #1;
    check("b2b_hold_result", 64'(data_result), 64'hFFFF_FFFA);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
